// File: rtl/if_stage_sram.sv
// if_stage_sram: LoongArch instruction-fetch stage driving an SRAM-like instruction port.
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   ds_allowin          decode can accept the presented instruction this cycle
//   br_bus[32:0]        {br_taken, br_target} from decode (combinational)
//   fs_to_ds_valid      fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus[63:0]  {inst, pc}
//   inst_sram_*         SRAM-like port: req/addr/addr_ok request phase, data_ok/rdata response
//   Optional (FS_PERF_CNT_EN): fs_fetch_cnt, fs_cancel_cnt handoff / dropped-instruction counters
module if_stage_sram #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef FS_PERF_CNT_EN
  ,
  output logic [31:0] fs_fetch_cnt,
  output logic [31:0] fs_cancel_cnt
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;
  state_t      state, state_nx;
  logic [31:0] pc_req, pc_nx, inst_buf, buf_nx, fs_pc, fs_pc_nx;
  logic        cancel, cancel_nx;
  wire         br_taken  = br_bus[32];
  wire  [31:0] br_target = br_bus[31:0];
  // reset gates req so nothing is issued while the stage is held in reset
  assign inst_sram_req   = reset & (state == S_REQ) & ~br_taken;
  assign inst_sram_addr  = pc_req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wstrb = 4'd0;
  assign inst_sram_wdata = 32'd0;
  assign fs_to_ds_valid  = (state == S_VALID) & ~br_taken;
  assign fs_to_ds_bus    = {inst_buf, fs_pc};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_REQ;
      pc_req   <= RESET_PC;
      cancel   <= 1'b0;
      inst_buf <= 32'd0;
      fs_pc    <= 32'd0;
    end else begin
      state    <= state_nx;
      pc_req   <= pc_nx;
      cancel   <= cancel_nx;
      inst_buf <= buf_nx;
      fs_pc    <= fs_pc_nx;
    end
  end
  always_comb begin
    state_nx  = state;
    pc_nx     = pc_req;
    cancel_nx = cancel;
    buf_nx    = inst_buf;
    fs_pc_nx  = fs_pc;
    case (state)
      S_REQ: begin
        if (br_taken) pc_nx = br_target;
        else if (inst_sram_addr_ok) begin
          fs_pc_nx = pc_req;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (br_taken) pc_nx = br_target;
        // a redirect while the word is in flight marks it wrong-path; it is dropped on arrival
        if (inst_sram_data_ok) begin
          if (cancel | br_taken) begin
            cancel_nx = 1'b0;
            state_nx  = S_REQ;
          end else begin
            buf_nx   = inst_sram_rdata;
            state_nx = S_VALID;
          end
        end else if (br_taken) cancel_nx = 1'b1;
      end
      S_VALID: begin
        if (br_taken) begin
          pc_nx    = br_target;
          state_nx = S_REQ;
        end else if (ds_allowin) begin
          pc_nx    = fs_pc + 32'd4;
          state_nx = S_REQ;
        end
      end
      default: state_nx = S_REQ;
    endcase
  end
`ifdef FS_PERF_CNT_EN
  wire handoff = fs_to_ds_valid & ds_allowin;
  wire drop    = ((state == S_WAIT) & inst_sram_data_ok & (cancel | br_taken)) |
                 ((state == S_VALID) & br_taken);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fs_fetch_cnt  <= 32'd0;
      fs_cancel_cnt <= 32'd0;
    end else begin
      fs_fetch_cnt  <= fs_fetch_cnt + {31'd0, handoff};
      fs_cancel_cnt <= fs_cancel_cnt + {31'd0, drop};
    end
  end
`endif
endmodule

// File: tb/tb_if_stage_sram.sv
// tb_if_stage_sram: directed scenarios plus randomized SRAM/decode traffic against a fetch-stream model.
module tb_if_stage_sram;
  localparam logic [31:0] RPC = 32'h1c000000;
  logic        clk = 0, reset = 0, ds_allowin = 0, br_taken = 0;
  logic [31:0] br_target = 0, rdata = 0;
  logic        addr_ok = 0, data_ok = 0;
  logic        valid, req, wr;
  logic [63:0] bus;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] wdata, addr;
`ifdef FS_PERF_CNT_EN
  logic [31:0] fetch_cnt, cancel_cnt;
`endif
  int tests = 0, fails = 0;

  if_stage_sram dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus({br_taken, br_target}),
    .fs_to_ds_valid(valid), .fs_to_ds_bus(bus),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_wstrb(wstrb),
    .inst_sram_wdata(wdata), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata)
`ifdef FS_PERF_CNT_EN
    , .fs_fetch_cnt(fetch_cnt), .fs_cancel_cnt(cancel_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a0f0f;
  endfunction

  task automatic adv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask
  task automatic idle();
    ds_allowin = 1; br_taken = 0; br_target = 0; addr_ok = 0; data_ok = 0; rdata = 0;
  endtask
  // request accepted, then 1-cycle response; leaves the stage in S_VALID
  task automatic fetch(input logic [31:0] a);
    addr_ok = 1; adv;
    addr_ok = 0; data_ok = 1; rdata = mem(a); adv;
    data_ok = 0;
  endtask

  task automatic test_reset();
    idle; reset = 0; adv; adv; smp;
    tests++; if ({req, valid} !== 2'b00) begin fails++; $display("FAIL reset_req_valid: got %b want 00", {req, valid}); end
    tests++; if (bus !== 64'd0) begin fails++; $display("FAIL reset_bus: got %h want 0", bus); end
    tests++; if ({wr, size, wstrb, wdata} !== {1'b0, 2'd2, 4'd0, 32'd0}) begin fails++; $display("FAIL tie_offs: got %h", {wr, size, wstrb, wdata}); end
    adv; reset = 1;
  endtask

  task automatic test_basic();
    addr_ok = 1; smp;
    tests++; if ({req, addr} !== {1'b1, RPC}) begin fails++; $display("FAIL first_req: got %b/%h want 1/%h", req, addr, RPC); end
    adv; addr_ok = 0; data_ok = 1; rdata = mem(RPC); smp;
    tests++; if ({req, valid} !== 2'b00) begin fails++; $display("FAIL wait_idle: got %b want 00", {req, valid}); end
    adv; data_ok = 0; smp;
    tests++; if ({valid, bus} !== {1'b1, mem(RPC), RPC}) begin fails++; $display("FAIL first_bus: got %b/%h want 1/%h", valid, bus, {mem(RPC), RPC}); end
    adv; smp;
    tests++; if ({req, addr} !== {1'b1, RPC + 32'd4}) begin fails++; $display("FAIL seq_req: got %b/%h want 1/%h", req, addr, RPC + 32'd4); end
    adv;
  endtask

  task automatic test_stall();
    ds_allowin = 0; fetch(RPC + 32'd4);
    for (int i = 0; i < 5; i++) begin
      smp;
      tests++; if ({valid, req, bus} !== {2'b10, mem(RPC + 32'd4), RPC + 32'd4}) begin fails++; $display("FAIL stall_hold: got %b%b/%h", valid, req, bus); end
      adv;
    end
    ds_allowin = 1; smp;
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL stall_release: got %b want 1", valid); end
    adv; smp;
    tests++; if ({req, addr} !== {1'b1, RPC + 32'd8}) begin fails++; $display("FAIL stall_next_req: got %b/%h want 1/%h", req, addr, RPC + 32'd8); end
    adv;
  endtask

  task automatic test_branch_wait();
    addr_ok = 1; adv;
    addr_ok = 0; br_taken = 1; br_target = 32'h1c000100; smp;
    tests++; if ({req, valid} !== 2'b00) begin fails++; $display("FAIL brw_idle: got %b want 00", {req, valid}); end
    adv; br_taken = 0; adv;
    data_ok = 1; rdata = mem(RPC + 32'd8); smp;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL brw_drop: got %b want 0", valid); end
    adv; data_ok = 0; smp;
    tests++; if ({req, valid, addr} !== {2'b10, 32'h1c000100}) begin fails++; $display("FAIL brw_redirect: got %b%b/%h want 10/1c000100", req, valid, addr); end
    adv;
  endtask

  task automatic test_branch_valid();
    fetch(32'h1c000100);
    ds_allowin = 1; br_taken = 1; br_target = 32'h1c000200; smp;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL brv_kill: got %b want 0", valid); end
    adv; br_taken = 0; smp;
    tests++; if ({req, addr} !== {1'b1, 32'h1c000200}) begin fails++; $display("FAIL brv_redirect: got %b/%h want 1/1c000200", req, addr); end
    adv;
  endtask

  task automatic test_reset_mid_wait();
    addr_ok = 1; adv;
    addr_ok = 0; #2; reset = 0; #1;
    tests++; if ({req, valid, bus} !== 66'd0) begin fails++; $display("FAIL async_reset: got %b%b/%h want 0", req, valid, bus); end
    adv; adv; reset = 1;
    data_ok = 1; rdata = 32'hbad0bad0; smp;
    tests++; if ({req, valid, addr} !== {2'b10, RPC}) begin fails++; $display("FAIL late_data: got %b%b/%h want 10/%h", req, valid, addr, RPC); end
    adv; data_ok = 0; addr_ok = 1; smp;
    tests++; if ({req, addr} !== {1'b1, RPC}) begin fails++; $display("FAIL post_reset_req: got %b/%h", req, addr); end
    adv; addr_ok = 0; data_ok = 1; rdata = mem(RPC); adv;
    data_ok = 0; smp;
    tests++; if ({valid, bus} !== {1'b1, mem(RPC), RPC}) begin fails++; $display("FAIL post_reset_bus: got %b/%h", valid, bus); end
    adv;
  endtask

  // Model: the architectural fetch stream. Each accepted request must hit the expected
  // next PC; each handoff must be the correct-path word for the last accepted PC.
  task automatic test_random();
    logic [31:0] exp_pc = RPC, infl_pc = 0, paddr = 0;
    logic        infl_v = 0, pending = 0;
    int          lat = 0, accepts = 0, handoffs = 0;
    idle; reset = 0; adv; reset = 1;
    for (int i = 0; i < 3030; i++) begin
      addr_ok    = (i < 3000) && ($urandom_range(0, 9) < 7);
      data_ok    = pending ? (lat == 0) : ($urandom_range(0, 19) == 0);
      rdata      = pending ? mem(paddr) : $urandom;
      br_taken   = (i < 3000) && ($urandom_range(0, 9) == 0);
      br_target  = $urandom & 32'hfffffffc;
      ds_allowin = (i >= 3000) || ($urandom_range(0, 9) < 6);
      smp;
      tests++; if (req && pending) begin fails++; $display("FAIL one_outstanding: req=%b while busy", req); end
      tests++; if (br_taken && (req || valid)) begin fails++; $display("FAIL br_suppress: got %b%b want 00", req, valid); end
      tests++; if (valid && !infl_v) begin fails++; $display("FAIL wrong_path_valid: got %b want 0 bus %h", valid, bus); end
      if (valid && ds_allowin && infl_v) begin
        tests++; if (bus !== {mem(infl_pc), infl_pc}) begin fails++; $display("FAIL handoff_bus: got %h want %h", bus, {mem(infl_pc), infl_pc}); end
        infl_v = 0; handoffs++;
      end
      if (pending) begin
        if (data_ok) pending = 0;
        else lat--;
      end
      if (req && addr_ok) begin
        tests++; if (addr !== exp_pc) begin fails++; $display("FAIL fetch_addr: got %h want %h", addr, exp_pc); end
        pending = 1; lat = $urandom_range(0, 3); paddr = addr;
        infl_pc = addr; infl_v = 1; exp_pc = addr + 32'd4; accepts++;
      end
      if (br_taken) begin exp_pc = br_target; infl_v = 0; end
      adv;
    end
    idle;
    tests++; if (handoffs < 100) begin fails++; $display("FAIL progress: got %0d handoffs want >=100", handoffs); end
`ifdef FS_PERF_CNT_EN
    tests++; if (fetch_cnt !== handoffs) begin fails++; $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, handoffs); end
    tests++; if (cancel_cnt !== accepts - handoffs) begin fails++; $display("FAIL cancel_cnt: got %0d want %0d", cancel_cnt, accepts - handoffs); end
`endif
  endtask

`ifdef FS_PERF_CNT_EN
  task automatic test_perf_cnt();
    idle; reset = 0; adv; reset = 1;
    fetch(RPC); adv;
    fetch(RPC + 32'd4); adv;
    fetch(RPC + 32'd8); br_taken = 1; br_target = 32'h1c000400; adv;
    br_taken = 0; addr_ok = 1; adv;
    addr_ok = 0; br_taken = 1; br_target = 32'h1c000800; data_ok = 1; adv;
    br_taken = 0; data_ok = 0; fetch(32'h1c000800); adv; smp;
    tests++; if ({fetch_cnt, cancel_cnt} !== {32'd3, 32'd2}) begin fails++; $display("FAIL perf_counts: got %0d/%0d want 3/2", fetch_cnt, cancel_cnt); end
    adv;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_branch_wait;
    test_branch_valid;
    test_reset_mid_wait;
`ifdef FS_PERF_CNT_EN
    test_perf_cnt;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
